// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of one handshake memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              pipe_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_rw
);

  arb_state_t        r_state;
  logic              r_last_grant;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ready;
  logic              r_dm_ready;
  logic              r_err_rw;

  logic              w_dm_req;
  logic              w_grant_dm;
  logic              w_grant_if;

  assign w_dm_req   = dm_read | dm_write;
  // On a tie the data side wins only if fetch had the previous grant.
  assign w_grant_dm = w_dm_req & (~if_req | (r_last_grant == GNT_IF));
  assign w_grant_if = if_req & ~w_grant_dm;

  // Grant in IDLE, hold the memory request until ack, then pulse ready in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_IF;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_ready   <= 1'b0;
      r_dm_ready   <= 1'b0;
      r_err_rw     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            r_state      <= DATA;
            r_last_grant <= GNT_DM;
            r_mem_req    <= 1'b1;
            r_mem_we     <= dm_write;
            r_mem_addr   <= dm_addr;
            r_mem_wdata  <= dm_wdata;
            if (dm_read && dm_write) begin
              r_err_rw <= 1'b1;
            end
          end else if (w_grant_if) begin
            r_state      <= INST;
            r_last_grant <= GNT_IF;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
          end
        end
        DATA, INST: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= RESP;
            if (r_state == DATA) begin
              r_dm_rdata <= mem_rdata;
              r_dm_ready <= 1'b1;
            end else begin
              r_if_rdata <= mem_rdata;
              r_if_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          // The finished requester still shows its old request here, so no grant.
          r_if_ready <= 1'b0;
          r_dm_ready <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_rdata   = r_if_rdata;
  assign if_ready   = r_if_ready;
  assign dm_rdata   = r_dm_rdata;
  assign dm_ready   = r_dm_ready;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign err_rw     = r_err_rw;
  assign pipe_stall = w_dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        pipe_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err_rw;

  int total = 0;
  int bad   = 0;

  // memory responder controls
  bit          mem_auto    = 1'b1;
  int          fixed_wait  = 0;
  bit          force_ack   = 1'b0;
  logic [31:0] force_rdata = 32'hBAD0_BAD0;

  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] ref_store [logic [31:0]];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .pipe_stall(pipe_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_rw(err_rw)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0000_0013;
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'hC3C3, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_lookup(input logic [31:0] a);
    if (ref_store.exists(a)) return ref_store[a];
    return init_word(a);
  endfunction

  // Handshake memory: acks after a chosen number of wait cycles; writes return ~wdata.
  initial begin : mem_model
    int cnt;
    int w;
    bit active;
    cnt = 0; w = 0; active = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = force_ack;
      if (force_ack) mem_rdata = force_rdata;
      if (!mem_auto || !rst_n || !mem_req) begin
        active = 0;
      end else begin
        if (!active) begin
          active = 1;
          cnt = 0;
          w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (cnt == w) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_store[mem_addr] = mem_wdata;
            mem_rdata = ~mem_wdata;
          end else begin
            mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_word(mem_addr);
          end
          active = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; dm_read = 0; dm_write = 0; dm_addr = '0; dm_wdata = '0;
    force_ack = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    mem_auto = 1; fixed_wait = 0;
    rst_n = 0;
    clear_inputs();
    if_req = 1; if_addr = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({mem_req, mem_we, if_ready, dm_ready, err_rw, pipe_stall} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 000000", {mem_req, mem_we, if_ready, dm_ready, err_rw, pipe_stall});
    end
    total++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    total++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: got if %h dm %h want 0", if_rdata, dm_rdata);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || if_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_grant: got req %b addr %h ready %b want 1 0 0", mem_req, mem_addr, if_ready);
    end
    @(negedge clk);
    total++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h0000_0013 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_fetch: got ready %b rdata %h req %b want 1 00000013 0", if_ready, if_rdata, mem_req);
    end
    if_req = 0;
    @(negedge clk);
    total++;
    if (if_ready !== 1'b0) begin
      bad++;
      $display("FAIL fetch_pulse_width: got %b want 0", if_ready);
    end
  endtask

  task automatic test_load_wait();
    int req_cnt;
    int stall_cnt;
    bit addr_ok;
    bit got;
    logic ready_stall;
    logic [31:0] rd;
    req_cnt = 0; stall_cnt = 0; addr_ok = 1; got = 0; ready_stall = 1'b1; rd = '0;
    fixed_wait = 3;
    repeat (2) @(negedge clk);
    dm_read = 1; dm_addr = 32'h100;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (pipe_stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (mem_addr !== 32'h100) addr_ok = 0;
      end
      if (dm_ready) begin
        got = 1; ready_stall = pipe_stall; rd = dm_rdata;
      end else begin
        @(negedge clk);
      end
    end
    dm_read = 0;
    total++;
    if (!got) begin bad++; $display("FAIL load_timeout: got no dm_ready want dm_ready"); end
    total++;
    if (req_cnt != 4) begin bad++; $display("FAIL load_req_cycles: got %0d want 4", req_cnt); end
    total++;
    if (!addr_ok) begin bad++; $display("FAIL load_addr_stable: got changing addr want 00000100"); end
    total++;
    if (stall_cnt != 5) begin bad++; $display("FAIL load_stall_cycles: got %0d want 5", stall_cnt); end
    total++;
    if (ready_stall !== 1'b0) begin bad++; $display("FAIL load_stall_at_ready: got %b want 0", ready_stall); end
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit [3:0] seq;
    int k;
    logic prev;
    seq = '0; k = 0; prev = 1'b0;
    apply_reset();
    mem_auto = 1; fixed_wait = 0;
    dm_write = 1; dm_addr = 32'h200; dm_wdata = 32'h1234_5678;
    if_req = 1; if_addr = 32'h40;
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && prev !== 1'b1) begin
        seq[k] = (mem_addr === 32'h200);
        total++;
        if (mem_addr === 32'h200) begin
          if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL store_bus: got we %b wdata %h want 1 12345678", mem_we, mem_wdata);
          end
        end else if (mem_we !== 1'b0 || mem_addr !== 32'h40) begin
          bad++;
          $display("FAIL fetch_bus: got we %b addr %h want 0 00000040", mem_we, mem_addr);
        end
        k++;
      end
      prev = mem_req;
    end
    clear_inputs();
    total++;
    if (k != 4) begin bad++; $display("FAIL b2b_grant_count: got %0d want 4", k); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seq[i] != ((i % 2) == 0)) begin
        bad++;
        $display("FAIL b2b_order[%0d]: got %s want %s", i, seq[i] ? "data" : "fetch", ((i % 2) == 0) ? "data" : "fetch");
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rw_conflict();
    bit got;
    got = 0;
    apply_reset();
    mem_auto = 1; fixed_wait = 1;
    total++;
    if (err_rw !== 1'b0) begin bad++; $display("FAIL err_before: got %b want 0", err_rw); end
    dm_read = 1; dm_write = 1; dm_addr = 32'h300; dm_wdata = 32'hCAFE_0001;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) got = 1;
    end
    total++;
    if (!got || mem_we !== 1'b1) begin bad++; $display("FAIL rw_is_write: got req %b we %b want 1 1", mem_req, mem_we); end
    total++;
    if (err_rw !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err_rw); end
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (dm_ready === 1'b1) got = 1;
    end
    total++;
    if (!got || dm_rdata !== ~32'hCAFE_0001) begin
      bad++;
      $display("FAIL rw_rdata: got ready %b rdata %h want 1 %h", got, dm_rdata, ~32'hCAFE_0001);
    end
    clear_inputs();
    repeat (4) @(negedge clk);
    total++;
    if (err_rw !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_rw); end
  endtask

  task automatic test_reset_mid_access();
    bit got;
    bit spurious;
    got = 0; spurious = 0;
    apply_reset();
    mem_auto = 0;
    dm_read = 1; dm_addr = 32'h100;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) got = 1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL abort_grant: got no mem_req want mem_req"); end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 0; dm_read = 0;
    #1;
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL abort_req_async: got %b want 0", mem_req); end
    total++;
    if ({mem_we, if_ready, dm_ready, err_rw, pipe_stall} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      bad++;
      $display("FAIL abort_outputs: got ctl %b addr %h wdata %h ird %h drd %h want all 0",
               {mem_we, if_ready, dm_ready, err_rw, pipe_stall}, mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk); force_ack = 1;
    @(negedge clk); force_ack = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_ready !== 1'b0 || dm_ready !== 1'b0 || mem_req !== 1'b0) spurious = 1;
    end
    total++;
    if (spurious) begin bad++; $display("FAIL late_ack_ignored: got activity want none"); end
    total++;
    if (dm_rdata !== 32'h0) begin bad++; $display("FAIL late_ack_rdata: got %h want 0", dm_rdata); end
    mem_auto = 1;
  endtask

  task automatic test_random_traffic(input int ncyc);
    logic        s_if, s_rd, s_wr, s_ack;
    logic [31:0] s_ia, s_da, s_wd;
    bit          busy, owner_dm, last_dm, m_we, m_err, exp_if, exp_dm;
    int          next_grant;
    logic [31:0] m_addr, m_wdata, m_rdata, m_if_rdata, m_dm_rdata;
    int          kind;
    apply_reset();
    mem_auto = 1; fixed_wait = -1;
    mem_store.delete();
    ref_store.delete();
    s_if = 0; s_rd = 0; s_wr = 0; s_ack = 0; s_ia = '0; s_da = '0; s_wd = '0;
    busy = 0; owner_dm = 0; last_dm = 0; m_we = 0; m_err = 0; next_grant = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk); #2;
      exp_if = 0; exp_dm = 0;
      if (busy && s_ack) begin
        busy = 0;
        next_grant = n + 2;
        if (owner_dm) begin exp_dm = 1; m_dm_rdata = m_rdata; end
        else begin exp_if = 1; m_if_rdata = m_rdata; end
      end else if (!busy && n >= next_grant) begin
        if ((s_rd || s_wr) && (!s_if || !last_dm)) begin
          busy = 1; owner_dm = 1; last_dm = 1;
          m_addr = s_da; m_we = s_wr; m_wdata = s_wd;
          if (s_rd && s_wr) m_err = 1;
          if (s_wr) begin ref_store[s_da] = s_wd; m_rdata = ~s_wd; end
          else m_rdata = ref_lookup(s_da);
        end else if (s_if) begin
          busy = 1; owner_dm = 0; last_dm = 0;
          m_addr = s_ia; m_we = 0;
          m_rdata = ref_lookup(s_ia);
        end
      end
      total++;
      if (if_ready !== exp_if || dm_ready !== exp_dm) begin
        bad++;
        $display("FAIL rnd_ready @%0d: got if %b dm %b want if %b dm %b", n, if_ready, dm_ready, exp_if, exp_dm);
      end
      total++;
      if (if_rdata !== m_if_rdata || dm_rdata !== m_dm_rdata) begin
        bad++;
        $display("FAIL rnd_rdata @%0d: got if %h dm %h want if %h dm %h", n, if_rdata, dm_rdata, m_if_rdata, m_dm_rdata);
      end
      total++;
      if (mem_req !== busy) begin
        bad++;
        $display("FAIL rnd_mem_req @%0d: got %b want %b", n, mem_req, busy);
      end
      total++;
      if (busy && (mem_addr !== m_addr || mem_we !== m_we || (m_we && mem_wdata !== m_wdata))) begin
        bad++;
        $display("FAIL rnd_mem_bus @%0d: got addr %h we %b wdata %h want addr %h we %b wdata %h",
                 n, mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wdata);
      end else if (!busy && mem_we !== 1'b0) begin
        bad++;
        $display("FAIL rnd_mem_we_idle @%0d: got %b want 0", n, mem_we);
      end
      total++;
      if (err_rw !== m_err) begin
        bad++;
        $display("FAIL rnd_err_rw @%0d: got %b want %b", n, err_rw, m_err);
      end
      s_ack = mem_ack;
      // fetch requester: hold until ready, then maybe issue another at once
      if (if_req) begin
        if (if_ready) begin
          if_req = ($urandom_range(0, 1) == 1);
          if_addr = 32'($urandom_range(0, 15)) << 2;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      // data requester: mostly reads and writes, occasionally both at once
      if ((dm_read || dm_write) && !dm_ready) begin
        // still waiting for completion
      end else if ($urandom_range(0, 2) == 0) begin
        kind = int'($urandom_range(0, 7));
        dm_read  = (kind == 0) || (kind >= 4);
        dm_write = (kind <= 3);
        dm_addr  = 32'($urandom_range(0, 15)) << 2;
        dm_wdata = $urandom;
      end else begin
        dm_read = 0; dm_write = 0;
      end
      s_if = if_req; s_rd = dm_read; s_wr = dm_write;
      s_ia = if_addr; s_da = dm_addr; s_wd = dm_wdata;
      #1;
      total++;
      if (pipe_stall !== ((dm_read | dm_write) & ~exp_dm)) begin
        bad++;
        $display("FAIL rnd_stall @%0d: got %b want %b", n, pipe_stall, (dm_read | dm_write) & ~exp_dm);
      end
    end
    clear_inputs();
    repeat (8) @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_load_wait();
    test_back_to_back();
    test_rw_conflict();
    test_reset_mid_access();
    test_random_traffic(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port, handshake-driven memory between the instruction-fetch stage and the MEM stage.
- The MEM-stage side is driven by the EX/MEM pipeline register outputs: `memread`, `memwrite`, `alu_result` as the address, and `rdata2out` as the write data.
- The block sequences each access through a small FSM, holds the memory interface stable until acknowledge, returns read data, and raises a pipeline stall while a data access is outstanding.
- Between back-to-back contenders it alternates grants so that neither requester starves.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ready`
- `if_ready`  out  1  one-cycle fetch completion pulse
- `dm_read`  in  1  data read request (EX/MEM `memread`)
- `dm_write`  in  1  data write request (EX/MEM `memwrite`)
- `dm_addr`  in  ADDR_W  data address (EX/MEM `alu_result`)
- `dm_wdata`  in  DATA_W  store data (EX/MEM `rdata2out`)
- `dm_rdata`  out  DATA_W  load data; valid while `dm_ready`
- `dm_ready`  out  1  one-cycle data completion pulse
- `pipe_stall`  out  1  high when (`dm_read`|`dm_write`) & ~`dm_ready`
- `mem_req`  out  1  memory request
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_ack`  in  1  memory acknowledge, one cycle
- `mem_rdata`  in  DATA_W  memory read data; valid with `mem_ack`
- `err_rw`  out  1  sticky flag: `dm_read` and `dm_write` were seen together at a grant

## Operation
- FSM states:
  - `IDLE`: no access in progress.
  - `DATA`: data access in flight.
  - `INST`: fetch in flight.
  - `RESP`: completion cycle.
- Grant decision is made in `IDLE` only:
  - Only a data request pending: grant data.
  - Only `if_req` pending: grant fetch.
  - Both pending: grant the requester opposite to `last_grant`. After reset `last_grant` = fetch, so data wins the first tie.
- On grant:
  - Latch address, write data and `we` into the `mem_*` registers.
  - Assert `mem_req`, enter `DATA` or `INST`, and update `last_grant`.
  - `we` = `dm_write`, which gives write priority.
  - If `dm_read` & `dm_write` are both high, set `err_rw` (sticky, cleared only by reset) and perform the write.
- In `DATA`/`INST`:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay constant until `mem_ack` is sampled high.
  - On that edge: drop `mem_req` and `mem_we`, capture `mem_rdata` into the granted port's rdata register, and enter `RESP`.
- In `RESP`:
  - Assert the granted port's ready for exactly one cycle. No new grant is made in this cycle, because the requester's stale request is still visible.
  - Next state: `IDLE`.
- The rdata registers hold their value until the next capture. After a write, `dm_rdata` = `mem_rdata` sampled at ack (don't-care content, but deterministic).
- A request that drops before its grant is simply not serviced. Requests sampled after the grant are ignored until `RESP`.
- `mem_ack` outside `DATA`/`INST` is ignored.

## Timing
- Reset (async assert, sync release):
  - State = `IDLE`, `last_grant` = fetch.
  - All outputs 0, including `mem_addr`, `mem_wdata`, both rdata outputs and `err_rw`.
- Reset mid-access: `mem_req` drops immediately and the access is abandoned. The memory model must tolerate this.
- Latency from request seen in `IDLE` to ready pulse is 2 + W cycles, where W = `mem_req`-high cycles before `mem_ack`:
  - Edge 0: grant.
  - Cycle 1: `mem_req` high.
  - Zero-wait ack sampled at edge 1: ready high in cycle 2.
  - Minimum 3 cycles request-to-ready including `RESP`.
- Back-to-back throughput is one access per 3 cycles at zero wait (`IDLE`→access→`RESP`).
- `pipe_stall` is combinational from inputs and the ready register. It falls in the `dm_ready` cycle so the pipeline advances on that edge.

## Structure
- Package `mem_arb_pkg`:
  - State enum `arb_state_t` {`IDLE`, `DATA`, `INST`, `RESP`}.
  - Grant-owner constants `GNT_IF`, `GNT_DM`.
  - Default width localparams.
- Single module; no sub-module needed. The FSM, request latch and `last_grant` bit live together.

## Test plan
- Reset with `if_req`=1 and zero-wait memory:
  - `mem_req` rises 1 cycle after reset release with `mem_addr`=`if_addr`=0x0000_0000.
  - `if_ready` pulses in cycle 3.
  - `if_rdata`=`mem_rdata`=0x0000_0013.
- Load (`dm_read`=1, `dm_addr`=0x100) with memory ack after 3 wait cycles:
  - `mem_req` high 4 cycles with constant address.
  - `dm_rdata`=0xDEAD_BEEF.
  - `pipe_stall` high for 5 cycles, then low in the `dm_ready` cycle.
- `dm_write` and `if_req` asserted together and held:
  - Order is data, fetch, data, fetch.
  - The store drives `mem_we`=1, `mem_wdata`=0x1234_5678, `mem_addr`=0x200.
  - No back-to-back repeat grant of the same port while the other is pending.
- `dm_read`=`dm_write`=1:
  - Write performed (`mem_we`=1).
  - `err_rw` goes to 1 and stays 1 after the requests drop.
- `rst_n` pulsed low while in `DATA` with ack pending:
  - `mem_req` drops asynchronously.
  - All outputs return to 0.
  - A late `mem_ack` after release produces no ready pulse.
